// File: rtl/tl_memtest_master.sv
// tl_memtest_master
//
// TileLink-UL initiator that self-tests a memory region. It writes word i of
// the region (address base + 4*i) with the value seed + i using PutFullData,
// then reads every word back with Get and checks the returned data. Only one
// transaction is ever outstanding.
//
// Ports
//   clk, rst         clock and asynchronous active-high reset
//   start            begin a test (sampled only while idle or done)
//   base_addr        region base; bits [1:0] are ignored
//   word_count       number of 32-bit words to test
//   seed             pattern seed
//   busy             high while a test is running
//   done             level, high once a test has finished
//   pass             valid while done; high iff no errors were seen
//   err_count        number of bad responses, saturating
//   first_err_addr   word address of the first bad response (0 if none)
//   a_*              TileLink-UL A channel (request, driven by this block)
//   d_*              TileLink-UL D channel (response, driven by the responder)

module tl_memtest_master #(
  parameter int SOURCE_WIDTH = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             base_addr,
  input  logic [COUNT_WIDTH-1:0]  word_count,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [COUNT_WIDTH-1:0]  err_count,
  output logic [31:0]             first_err_addr,
  output logic [2:0]              a_opcode,
  output logic [2:0]              a_param,
  output logic [3:0]              a_size,
  output logic [SOURCE_WIDTH-1:0] a_source,
  output logic [31:0]             a_address,
  output logic [3:0]              a_mask,
  output logic [31:0]             a_data,
  output logic                    a_corrupt,
  output logic                    a_valid,
  input  logic                    a_ready,
  input  logic [2:0]              d_opcode,
  input  logic [1:0]              d_param,
  input  logic [3:0]              d_size,
  input  logic [SOURCE_WIDTH-1:0] d_source,
  input  logic                    d_denied,
  input  logic [31:0]             d_data,
  input  logic                    d_corrupt,
  input  logic                    d_valid,
  output logic                    d_ready
);

  localparam logic [2:0] OP_PUT_FULL     = 3'd0;
  localparam logic [2:0] OP_GET          = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK   = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_D = 3'd1;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t                 state;
  logic [31:0]            base_q;
  logic [31:0]            seed_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] idx;

  logic [31:0] word_addr;
  logic [31:0] next_addr;
  logic [31:0] exp_data;
  logic [31:0] next_data;
  logic        last_word;
  logic        d_fire;
  logic        rsp_err;

  // Every A-channel field except address/data/opcode is fixed for the
  // single-beat, full-word accesses this block issues.
  assign a_param   = 3'd0;
  assign a_size    = 4'd2;
  assign a_source  = '0;
  assign a_mask    = 4'hF;
  assign a_corrupt = 1'b0;

  assign pass = done && (err_count == '0);

  // Response metadata is not needed: there is only one transaction in
  // flight, so the source ID and size carry no information.
  logic unused_d_fields;
  assign unused_d_fields = ^{d_param, d_size, d_source};

  // Address/data of the current word and its successor, plus the check of
  // the response arriving for the current word.
  always_comb begin
    word_addr = base_q + (32'(idx) << 2);
    next_addr = word_addr + 32'd4;
    exp_data  = seed_q + 32'(idx);
    next_data = exp_data + 32'd1;
    last_word = (idx == count_q - COUNT_WIDTH'(1));
    d_fire    = d_valid && d_ready;
    rsp_err   = 1'b0;
    case (state)
      WR_RESP: rsp_err = (d_opcode != OP_ACCESS_ACK) || d_denied;
      RD_RESP: rsp_err = (d_opcode != OP_ACCESS_ACK_D) || d_denied ||
                         d_corrupt || (d_data != exp_data);
      default: rsp_err = 1'b0;
    endcase
  end

  // Main sequencer. All bus and status outputs are registered here so that
  // a_valid never depends combinationally on a_ready, and the next request
  // is loaded in the same edge that accepts the previous response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      base_q         <= '0;
      seed_q         <= '0;
      count_q        <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      a_valid        <= 1'b0;
      a_opcode       <= 3'd0;
      a_address      <= '0;
      a_data         <= '0;
      d_ready        <= 1'b0;
    end else begin
      // Error bookkeeping: err_count==0 identifies the first error.
      if (d_fire && rsp_err) begin
        if (err_count != '1) begin
          err_count <= err_count + COUNT_WIDTH'(1);
        end
        if (err_count == '0) begin
          first_err_addr <= word_addr;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            base_q         <= {base_addr[31:2], 2'b00};
            seed_q         <= seed;
            count_q        <= word_count;
            idx            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= WR_REQ;
              done      <= 1'b0;
              busy      <= 1'b1;
              a_valid   <= 1'b1;
              a_opcode  <= OP_PUT_FULL;
              a_address <= {base_addr[31:2], 2'b00};
              a_data    <= seed;
            end
          end
        end

        WR_REQ: begin
          if (a_valid && a_ready) begin
            a_valid <= 1'b0;
            d_ready <= 1'b1;
            state   <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (d_valid) begin
            d_ready <= 1'b0;
            a_valid <= 1'b1;
            if (last_word) begin
              idx       <= '0;
              state     <= RD_REQ;
              a_opcode  <= OP_GET;
              a_address <= base_q;
              a_data    <= '0;
            end else begin
              idx       <= idx + COUNT_WIDTH'(1);
              state     <= WR_REQ;
              a_opcode  <= OP_PUT_FULL;
              a_address <= next_addr;
              a_data    <= next_data;
            end
          end
        end

        RD_REQ: begin
          if (a_valid && a_ready) begin
            a_valid <= 1'b0;
            d_ready <= 1'b1;
            state   <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (d_valid) begin
            d_ready <= 1'b0;
            if (last_word) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx       <= idx + COUNT_WIDTH'(1);
              state     <= RD_REQ;
              a_valid   <= 1'b1;
              a_opcode  <= OP_GET;
              a_address <= next_addr;
              a_data    <= '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_memtest_master.sv
// tb_tl_memtest_master
//
// Bench for tl_memtest_master. A small TileLink-UL memory responder lives in
// the bench and can stall a_ready, flip read data at one address, deny one
// write and corrupt one read. Expected traffic, error counts, first error
// address and run length come from a word-list model of the test.

module tb_tl_memtest_master;

  localparam int SW = 1;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   base_addr;
  logic [CW-1:0] word_count;
  logic [31:0]   seed;
  logic          busy, done, pass;
  logic [CW-1:0] err_count;
  logic [31:0]   first_err_addr;
  logic [2:0]    a_opcode, a_param;
  logic [3:0]    a_size, a_mask;
  logic [SW-1:0] a_source;
  logic [31:0]   a_address, a_data;
  logic          a_corrupt, a_valid, a_ready;
  logic [2:0]    d_opcode;
  logic [1:0]    d_param;
  logic [3:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0]   d_data;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tl_memtest_master #(.SOURCE_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt), .a_valid(a_valid),
    .a_ready(a_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid),
    .d_ready(d_ready)
  );

  assign d_param  = 2'd0;
  assign d_size   = 4'd2;
  assign d_source = '0;

  // Responder configuration (written only by the stimulus process)
  int          stall_cycles;
  logic        flip_en;
  logic [31:0] flip_addr;
  int          deny_wr_n;
  int          corrupt_rd_n;

  // Responder state and traffic log
  int          stall_left;
  int          wr_seen, rd_seen;
  int          stab_viol, const_viol;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rsp_rdata;
  logic [2:0]  log_op[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        prev_stalled;
  logic [2:0]  prev_op;
  logic [31:0] prev_addr, prev_data;

  assign a_ready = (stall_left == 0);

  // Memory responder: one-cycle D response after each A handshake, optional
  // a_ready stalls, fault injection, and a stability monitor for stalled
  // requests.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid      <= 1'b0;
      d_opcode     <= 3'd0;
      d_denied     <= 1'b0;
      d_corrupt    <= 1'b0;
      d_data       <= 32'd0;
      stall_left   <= stall_cycles;
      wr_seen      = 0;
      rd_seen      = 0;
      stab_viol    <= 0;
      const_viol   <= 0;
      prev_stalled <= 1'b0;
      log_op.delete();
      log_addr.delete();
      log_data.delete();
      mem.delete();
    end else begin
      if (prev_stalled && (!a_valid || a_opcode !== prev_op ||
          a_address !== prev_addr || a_data !== prev_data))
        stab_viol <= stab_viol + 1;
      prev_stalled <= a_valid && !a_ready;
      prev_op      <= a_opcode;
      prev_addr    <= a_address;
      prev_data    <= a_data;
      if (a_valid && (a_param !== 3'd0 || a_size !== 4'd2 || a_mask !== 4'hF ||
          a_corrupt !== 1'b0 || a_source !== '0))
        const_viol <= const_viol + 1;
      if (d_valid && d_ready) d_valid <= 1'b0;
      if (a_valid && a_ready) begin
        log_op.push_back(a_opcode);
        log_addr.push_back(a_address);
        log_data.push_back(a_data);
        stall_left <= stall_cycles;
        d_valid    <= 1'b1;
        d_denied   <= 1'b0;
        d_corrupt  <= 1'b0;
        d_data     <= 32'd0;
        if (a_opcode == 3'd0) begin
          mem[a_address] = a_data;
          wr_seen = wr_seen + 1;
          d_opcode <= 3'd0;
          if (wr_seen == deny_wr_n) d_denied <= 1'b1;
        end else begin
          rd_seen = rd_seen + 1;
          d_opcode <= 3'd1;
          rsp_rdata = mem.exists(a_address) ? mem[a_address] : 32'd0;
          if (flip_en && a_address == flip_addr) rsp_rdata = rsp_rdata ^ 32'd1;
          d_data <= rsp_rdata;
          if (rd_seen == corrupt_rd_n) d_corrupt <= 1'b1;
        end
      end else if (a_valid && stall_left > 0) begin
        stall_left <= stall_left - 1;
      end
    end
  end

  // Reference model results
  logic [2:0]  exp_op[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_err;
  logic [31:0] exp_first;
  int          exp_cycles;
  logic        start_busy, start_valid;

  // Word list of the test: all writes, then all reads, each word judged
  // against the injected faults in the order the bus sees them.
  task automatic model_expect(input logic [31:0] b, input int wc, input logic [31:0] s);
    logic [31:0] addr;
    logic        bad;
    exp_op.delete(); exp_addr.delete(); exp_data.delete();
    exp_err   = 0;
    exp_first = 32'd0;
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < wc; i++) begin
        addr = (b & 32'hFFFF_FFFC) + 32'(i * 4);
        exp_op.push_back(phase == 0 ? 3'd0 : 3'd4);
        exp_addr.push_back(addr);
        exp_data.push_back(phase == 0 ? s + 32'(i) : 32'd0);
        if (phase == 0) bad = (i + 1 == deny_wr_n);
        else            bad = (flip_en && addr == flip_addr) || (i + 1 == corrupt_rd_n);
        if (bad) begin
          if (exp_err == 0) exp_first = addr;
          exp_err++;
        end
      end
    end
    exp_cycles = 2 * wc * (2 + stall_cycles);
  endtask

  task automatic clear_faults();
    stall_cycles = 0; flip_en = 1'b0; flip_addr = 32'd0;
    deny_wr_n = 0; corrupt_rd_n = 0;
  endtask

  // Resets DUT and responder, starts one test, waits for done (bounded) and
  // scoreboards the recorded bus traffic. restart_at > 0 pulses start with
  // different inputs at that cycle, which must be ignored.
  task automatic run_test(input logic [31:0] b, input int wc, input logic [31:0] s,
                          input int restart_at, output int cycles);
    model_expect(b, wc, s);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    base_addr = b; word_count = 16'(wc); seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_busy  = busy;
    start_valid = a_valid;
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == restart_at) begin
        start = 1'b1; base_addr = $urandom; word_count = 16'd1; seed = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", done, cycles);
    end
    compared++;
    compared++;
    if (log_op.size() !== exp_op.size()) begin
      mismatched++;
      $display("[TB] FAIL txn_count: got %0d transactions, required %0d", log_op.size(), exp_op.size());
    end
    for (int i = 0; i < log_op.size() && i < exp_op.size(); i++) begin
      compared++;
      if ({log_op[i], log_addr[i], log_data[i]} !== {exp_op[i], exp_addr[i], exp_data[i]}) begin
        mismatched++;
        $display("[TB] FAIL txn[%0d]: got op=%0d addr=%h data=%h, required op=%0d addr=%h data=%h",
                 i, log_op[i], log_addr[i], log_data[i], exp_op[i], exp_addr[i], exp_data[i]);
      end
    end
    compared++;
    if (const_viol !== 0) begin
      mismatched++;
      $display("[TB] FAIL a_const_fields: %0d bad cycles, required 0", const_viol);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (a_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_a_valid: got %b required 0", a_valid); end
    compared++; if (d_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_d_ready: got %b required 0", d_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_done: got %b required 0", done); end
    compared++; if (pass !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_pass: got %b required 0", pass); end
    compared++; if (err_count !== '0) begin mismatched++; $display("[TB] FAIL rst_err_count: got %h required 0", err_count); end
    compared++; if (first_err_addr !== 32'd0) begin mismatched++; $display("[TB] FAIL rst_first_err: got %h required 0", first_err_addr); end
  endtask

  task automatic test_basic();
    int cyc;
    clear_faults();
    run_test(32'h100, 4, 32'hA5A5_0000, 0, cyc);
    compared++; if (start_busy !== 1'b1 || start_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_start: busy=%b a_valid=%b required 1/1", start_busy, start_valid); end
    compared++; if (cyc !== 16) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d cycles required 16", cyc); end
    compared++; if (pass !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_pass: pass=%b busy=%b required 1/0", pass, busy); end
    compared++; if (err_count !== 16'd0 || first_err_addr !== 32'd0) begin mismatched++; $display("[TB] FAIL basic_errs: err=%0d first=%h required 0/0", err_count, first_err_addr); end
  endtask

  task automatic test_stall();
    int cyc;
    clear_faults();
    stall_cycles = 3;
    run_test(32'h100, 4, 32'hA5A5_0000, 2, cyc);
    compared++; if (cyc !== 40) begin mismatched++; $display("[TB] FAIL stall_latency: got %0d cycles required 40", cyc); end
    compared++; if (stab_viol !== 0) begin mismatched++; $display("[TB] FAIL stall_stable: %0d unstable cycles required 0", stab_viol); end
    compared++; if (pass !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_pass: got %b required 1", pass); end
  endtask

  task automatic test_read_flip();
    int cyc;
    clear_faults();
    flip_en = 1'b1; flip_addr = 32'h108;
    run_test(32'h100, 4, 32'hA5A5_0000, 0, cyc);
    compared++; if (err_count !== 16'd1) begin mismatched++; $display("[TB] FAIL flip_err_count: got %0d required 1", err_count); end
    compared++; if (first_err_addr !== 32'h108) begin mismatched++; $display("[TB] FAIL flip_first_err: got %h required 00000108", first_err_addr); end
    compared++; if (pass !== 1'b0) begin mismatched++; $display("[TB] FAIL flip_pass: got %b required 0", pass); end
  endtask

  task automatic test_denied_corrupt();
    int cyc;
    clear_faults();
    deny_wr_n = 2; corrupt_rd_n = 4;
    run_test(32'h100, 4, 32'hA5A5_0000, 0, cyc);
    compared++; if (err_count !== 16'd2) begin mismatched++; $display("[TB] FAIL dc_err_count: got %0d required 2", err_count); end
    compared++; if (first_err_addr !== 32'h104) begin mismatched++; $display("[TB] FAIL dc_first_err: got %h required 00000104", first_err_addr); end
    compared++; if (pass !== 1'b0) begin mismatched++; $display("[TB] FAIL dc_pass: got %b required 0", pass); end
  endtask

  task automatic test_zero_count();
    int cyc;
    clear_faults();
    run_test(32'h100, 0, 32'h1234_5678, 0, cyc);
    compared++; if (cyc !== 0 || start_valid !== 1'b0 || start_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_done: cycles=%0d a_valid=%b busy=%b required 0/0/0", cyc, start_valid, start_busy); end
    compared++; if (pass !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_pass: got %b required 1", pass); end
  endtask

  task automatic test_wrap();
    int cyc;
    clear_faults();
    run_test(32'hFFFF_FFFC, 2, 32'hFFFF_FFFF, 0, cyc);
    compared++; if (log_addr.size() < 2 || log_addr[1] !== 32'd0) begin mismatched++; $display("[TB] FAIL wrap_addr: second address wrong (%0d txns), required 00000000", log_addr.size()); end
    compared++; if (pass !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_pass: got %b required 1", pass); end
  endtask

  task automatic test_unaligned();
    int cyc;
    clear_faults();
    run_test(32'h103, 2, 32'h0000_0010, 0, cyc);
    compared++; if (log_addr.size() < 1 || log_addr[0] !== 32'h100) begin mismatched++; $display("[TB] FAIL unaligned_addr: first address wrong (%0d txns), required 00000100", log_addr.size()); end
    compared++; if (pass !== 1'b1) begin mismatched++; $display("[TB] FAIL unaligned_pass: got %b required 1", pass); end
  endtask

  task automatic test_random();
    int          cyc, wc;
    logic [31:0] b, s;
    for (int n = 0; n < 8; n++) begin
      clear_faults();
      b  = $urandom;
      s  = $urandom;
      wc = $urandom_range(1, 6);
      stall_cycles = $urandom_range(0, 2);
      flip_en      = 1'($urandom_range(0, 1));
      flip_addr    = (b & 32'hFFFF_FFFC) + 32'($urandom_range(0, wc - 1) * 4);
      deny_wr_n    = $urandom_range(0, wc);
      corrupt_rd_n = $urandom_range(0, wc);
      run_test(b, wc, s, 0, cyc);
      compared++; if (cyc !== exp_cycles) begin mismatched++; $display("[TB] FAIL rand%0d_latency: got %0d required %0d", n, cyc, exp_cycles); end
      compared++; if (err_count !== 16'(exp_err)) begin mismatched++; $display("[TB] FAIL rand%0d_err_count: got %0d required %0d", n, err_count, exp_err); end
      compared++; if (first_err_addr !== exp_first) begin mismatched++; $display("[TB] FAIL rand%0d_first_err: got %h required %h", n, first_err_addr, exp_first); end
      compared++; if (pass !== (exp_err == 0)) begin mismatched++; $display("[TB] FAIL rand%0d_pass: got %b required %b", n, pass, exp_err == 0); end
    end
  endtask

  task automatic test_reset_midway();
    int cyc;
    int waited;
    clear_faults();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    base_addr = 32'h100; word_count = 16'd4; seed = 32'hA5A5_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (!(log_op.size() == 3 && d_ready === 1'b1) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    compared++;
    if (waited >= 200) begin
      mismatched++;
      $display("[TB] FAIL midrst_reach: third write response not reached, txns=%0d", log_op.size());
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({a_valid, d_ready, busy, done, pass, err_count, first_err_addr} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrst_outputs: a_valid=%b d_ready=%b busy=%b done=%b pass=%b err=%h first=%h required all 0",
               a_valid, d_ready, busy, done, pass, err_count, first_err_addr);
    end
    @(negedge clk); rst = 1'b0;
    run_test(32'h100, 4, 32'hA5A5_0000, 0, cyc);
    compared++; if (pass !== 1'b1 || cyc !== 16) begin mismatched++; $display("[TB] FAIL midrst_rerun: pass=%b cycles=%0d required 1/16", pass, cyc); end
  endtask

  initial begin
    clear_faults();
    start = 1'b0; base_addr = 32'd0; word_count = '0; seed = 32'd0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_read_flip();
    test_denied_corrupt();
    test_zero_count();
    test_wrap();
    test_unaligned();
    test_random();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
